cmp_seq_lcu: RTL and testbench
==============================

Name: cmp_seq_lcu

Overview:
- Multi-cycle magnitude comparator that feeds the same eight flags (gtu, gts, ltu, lts, geu, ges, leu, les) as the combinational compare-to-LCU stage, for paths too wide or slow for a single-cycle compare.
- Scans operands MSB-first, one CHUNK-bit slice per clock.
- Derives signed results from the unsigned scan plus operand sign bits.
- Valid/ready handshake on both sides; sits between operand registers and the flag consumer.

Parameters:
- WIDTH, 14, operand width in bits (>= 2).
- CHUNK, 4, bits compared per SCAN cycle (1..WIDTH).
- NCHUNK (localparam), ceil(WIDTH/CHUNK), number of slices; the top slice may be partial and is zero-extended.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  flags valid.
- out_ready  in  1  consumer takes flags.
- gtu, gts, ltu, lts  out  1 each  A>B / A<B, unsigned and signed.
- geu, ges, leu, les  out  1 each  A>=B / A<=B, unsigned and signed.

Behaviour:
- Reset state:
  - State IDLE, in_ready=1, out_valid=0, all eight flags=0, slice index=NCHUNK-1.
  - rst overrides everything, including mid-SCAN or mid-DONE. The in-flight transaction is dropped and no flags are produced for it.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a and b, set idx=NCHUNK-1, go to SCAN, in_ready=0.
- SCAN, one slice per clock:
  - If slice idx of A != slice idx of B: record ugt = (slice A > slice B), set ueq=0, go to DONE.
  - Else if idx==0: ueq=1, ugt=0, go to DONE.
  - Else: idx <= idx-1.
- Flag computation, registered on the SCAN->DONE edge:
  - gtu=ugt, ltu=~ugt&~ueq, geu=ugt|ueq, leu=~ugt.
  - Let sa=A[WIDTH-1], sb=B[WIDTH-1].
  - If sa==sb: signed flags equal the unsigned flags.
  - Else: gts=~sa, lts=sa, ges=~sa, les=sa.
- DONE:
  - out_valid=1; flags held stable while out_valid&&!out_ready.
  - On out_ready: out_valid<=0, go to IDLE; in_ready returns to 1 on the following cycle. There is no same-cycle re-accept.
- Latency: out_valid rises k clock edges after the accept edge, where k = number of slices examined (1..NCHUNK).
- Flags change only on entry to DONE. In IDLE they keep the last result; after reset they are 0.
- in_valid, a and b are ignored outside IDLE. The registered operands are immune to input changes during SCAN.
- Simultaneous rst and handshake: rst wins.
- Equal operands: geu=leu=ges=les=1, gt/lt flags=0.

Optional Feature:
- CMP_EARLY_EXIT_EN.
- Defined: SCAN exits on the first unequal slice, as above; latency is data-dependent, 1..NCHUNK.
- Undefined: SCAN always runs all NCHUNK slices, latency is constant NCHUNK.
  - The first unequal slice, scanning MSB-first, decides ugt.
  - Later slices must not overwrite the decision.
  - Flags are identical to the defined case.

Test Plan (WIDTH=14, CHUNK=4, NCHUNK=4, macro defined unless noted):
- a=0x2A5B, b=0x2A5B -> out_valid 4 edges after accept; geu=leu=ges=les=1, others 0.
- a=0x3000, b=0x0001 -> top slice differs, out_valid after 1 edge; gtu=1, geu=1, lts=1, les=1, others 0.
- a=0x0005, b=0x0004 -> out_valid after 4 edges; gtu=gts=geu=ges=1, others 0.
- Same stimulus as a=0x3000/b=0x0001 with macro undefined -> identical flags, out_valid exactly 4 edges after accept.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands -> flags and out_valid stable, in_ready=0, new operands not captured. Raise out_ready -> out_valid drops, in_ready=1 next cycle.
- Reset: assert rst for 1 cycle during SCAN of a=0x0005/b=0x0004 -> next edge in_ready=1, out_valid=0, flags=0. A following a=0x0001, b=0x0002 gives ltu=lts=leu=les=1.

Source files
------------

// File: rtl/cmp_seq_lcu.sv
// Multi-cycle MSB-first magnitude comparator producing the eight LCU compare flags.
// Optional `CMP_EARLY_EXIT_EN: stop scanning at the first unequal slice (else always NCHUNK cycles).
module cmp_seq_lcu #(
  parameter int WIDTH = 14,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gtu,
  output logic             gts,
  output logic             ltu,
  output logic             lts,
  output logic             geu,
  output logic             ges,
  output logic             leu,
  output logic             les
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = NCHUNK * CHUNK;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0]    idx;
  logic             decided, ugt_r;
  logic [7:0]       flags, flags_n;

  // Zero-extended operands viewed as slices; the top slice may be partial.
  logic [NCHUNK-1:0][CHUNK-1:0] sla, slb;
  logic [CHUNK-1:0] ca, cb;
  logic ne, sgt, last, fin, f_ugt, f_ueq, sa, sb;
  logic s_gt, s_lt, s_ge, s_le;

  assign sla  = PW'(ra);
  assign slb  = PW'(rb);
  assign ca   = sla[idx];
  assign cb   = slb[idx];
  assign ne   = (ca != cb);
  assign sgt  = (ca > cb);
  assign last = (idx == '0);
  assign sa   = ra[WIDTH-1];
  assign sb   = rb[WIDTH-1];

`ifdef CMP_EARLY_EXIT_EN
  assign fin = ne || last;
`else
  assign fin = last;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign {gtu, gts, ltu, lts, geu, ges, leu, les} = flags;

  always_comb begin
    state_n = state;
    f_ugt   = 1'b0;
    f_ueq   = 1'b0;
    s_gt    = 1'b0;
    s_lt    = 1'b0;
    s_ge    = 1'b0;
    s_le    = 1'b0;
    case (state)
      IDLE:    if (in_valid) state_n = SCAN;
      SCAN:    if (fin) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // An earlier (more significant) unequal slice always wins over the current one.
    if (decided)  f_ugt = ugt_r;
    else if (ne)  f_ugt = sgt;
    else          f_ueq = 1'b1;
    if (sa == sb) begin
      s_gt = f_ugt;
      s_lt = ~f_ugt & ~f_ueq;
      s_ge = f_ugt | f_ueq;
      s_le = ~f_ugt;
    end else begin
      s_gt = ~sa;
      s_lt = sa;
      s_ge = ~sa;
      s_le = sa;
    end
    flags_n = {f_ugt, s_gt, ~f_ugt & ~f_ueq, s_lt, f_ugt | f_ueq, s_ge, ~f_ugt, s_le};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ra      <= '0;
      rb      <= '0;
      idx     <= IDX_TOP;
      decided <= 1'b0;
      ugt_r   <= 1'b0;
      flags   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          ra      <= a;
          rb      <= b;
          idx     <= IDX_TOP;
          decided <= 1'b0;
          ugt_r   <= 1'b0;
        end
        SCAN: begin
          if (!decided && ne) begin
            decided <= 1'b1;
            ugt_r   <= sgt;
          end
          if (fin) flags <= flags_n;
          else     idx   <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_seq_lcu.sv
// Randomized self-checking bench for cmp_seq_lcu against an arithmetic reference model.
module tb_cmp_seq_lcu;
  localparam int WIDTH  = 14;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b;
  logic gtu, gts, ltu, lts, geu, ges, leu, les;
  logic [7:0] fl;
  int n_cmp = 0;
  int n_bad = 0;

  assign fl = {gtu, gts, ltu, lts, geu, ges, leu, les};

  cmp_seq_lcu #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .gtu(gtu), .gts(gts), .ltu(ltu), .lts(lts),
    .geu(geu), .ges(ges), .leu(leu), .les(les)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference flags straight from integer comparisons, order {gtu,gts,ltu,lts,geu,ges,leu,les}.
  function automatic logic [7:0] exp_flags(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    logic signed [WIDTH-1:0] xa, xb;
    xa = va;
    xb = vb;
    return {va > vb, xa > xb, va < vb, xa < xb, va >= vb, xa >= xb, va <= vb, xa <= vb ? xa <= xb : xa <= xb};
  endfunction

  function automatic int exp_lat(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    int ua, ub, m;
    ua = int'(va);
    ub = int'(vb);
    m  = (1 << CHUNK) - 1;
    if (!EARLY) return NCHUNK;
    for (int s = NCHUNK - 1; s >= 0; s--)
      if (((ua >> (s * CHUNK)) & m) != ((ub >> (s * CHUNK)) & m)) return NCHUNK - s;
    return NCHUNK;
  endfunction

  task automatic run(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input int bp);
    int n;
    logic [7:0] ef;
    ef = exp_flags(va, vb);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = va; b = vb;
    @(negedge clk);
    in_valid = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
    chk("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < NCHUNK + 4) begin @(negedge clk); n++; end
    chk("latency", n, exp_lat(va, vb));
    chk("flags", fl, ef);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_flags", fl, ef);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("idle_flags_hold", fl, ef);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int mode, sl;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", fl, 0);
    rst = 1'b0;
    @(negedge clk);

    run(14'h2A5B, 14'h2A5B, 0);
    run(14'h3000, 14'h0001, 3);
    run(14'h0005, 14'h0004, 0);
    run(14'h1FFF, 14'h2000, 1);
    run(14'h0000, 14'h3FFF, 0);

    for (int t = 0; t < 60; t++) begin
      ra = WIDTH'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0)      rb = WIDTH'($urandom);
      else if (mode == 1) rb = ra;
      else begin
        sl = $urandom_range(0, NCHUNK - 1);
        rb = ra ^ WIDTH'(($urandom_range(1, (1 << CHUNK) - 1)) << (sl * CHUNK));
      end
      run(ra, rb, $urandom_range(0, 3));
    end

    // Reset in the middle of a scan drops the transaction.
    in_valid = 1'b1; a = 14'h0005; b = 14'h0004;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flags", fl, 0);
    repeat (NCHUNK + 1) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);
    run(14'h0001, 14'h0002, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
